// File: rtl/pnl_serial_shifter.sv
// Front-panel serial shift engine: sends a parallel word MSB-first on sdo/sclk, pulses le,
// and (when PNL_SER_READBACK_EN is defined) captures the word returned on sdi.
module pnl_serial_shifter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LE_W    = 2
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sdo,
  input  logic              sdi,
  output logic              sclk,
  output logic              le,
  output logic              sta
);

  localparam int unsigned MaxDiv = (CLK_DIV > LE_W) ? CLK_DIV : LE_W;
  localparam int unsigned DivW   = (MaxDiv > 1) ? $clog2(MaxDiv) : 1;
  localparam int unsigned BitW   = $clog2(DATA_W) + 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] LeLast  = DivW'(LE_W - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLatch,
    StFin
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              capture;
  logic              finish;

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    capture = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      // FIN accepts start too, giving back-to-back transfers.
      StIdle, StFin: begin
        if (start) begin
          sh_d    = tx_data;
          bit_d   = '0;
          div_d   = '0;
          state_d = StShiftLo;
        end else begin
          state_d = StIdle;
        end
      end
      StShiftLo: begin
        if (div_q == DivLast) begin
          div_d   = '0;
          state_d = StShiftHi;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StShiftHi: begin
        capture = (div_q == '0);
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == BitLast) begin
            state_d = StLatch;
          end else begin
            bit_d   = bit_q + BitW'(1);
            sh_d    = {sh_q[DATA_W-2:0], 1'b0};
            state_d = StShiftLo;
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StLatch: begin
        if (div_q == LeLast) begin
          div_d   = '0;
          finish  = 1'b1;
          state_d = StFin;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StShiftLo) || (state_q == StShiftHi) || (state_q == StLatch);
  assign sta  = busy;
  assign sclk = (state_q == StShiftHi);
  assign le   = (state_q == StLatch);
  assign done = (state_q == StFin);
  // sdo only moves when sh_q shifts, which happens on the HI->LO transition.
  assign sdo  = busy & sh_q[DATA_W-1];

`ifdef PNL_SER_READBACK_EN
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_q;

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      rx_sh_q <= '0;
      rx_q    <= '0;
    end else begin
      if (capture) begin
        rx_sh_q <= {rx_sh_q[DATA_W-2:0], sdi};
      end
      if (finish) begin
        rx_q <= rx_sh_q;
      end
    end
  end

  assign rx_data = rx_q;
`else
  logic unused_sig;
  assign unused_sig = ^{sdi, capture, finish};
  assign rx_data    = '0;
`endif

endmodule
